instruction_fetch: RTL

Fetch stage directly upstream of the instruction ROM. It owns the program counter, drives the ROM address each cycle, captures the combinational ROM output, and queues {address, instruction} pairs in a small buffer. Entries go to decode over a valid/ready handshake. It also handles branch/jump redirects (flush and reload the PC) and a halt request.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_buffer.sv | 93 +++++++++
 rtl/instruction_fetch.sv | 97 +++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants, also consumed by decode.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_pkg;

    localparam int FETCH_ADDRESS_WIDTH = 16;
    localparam int FETCH_DATA_WIDTH    = 16;
    localparam int FETCH_BUFFER_DEPTH  = 2;

    localparam logic [FETCH_ADDRESS_WIDTH-1:0] FETCH_RESET_VECTOR = 16'h0000;

    // One fetched instruction together with the address it was read from.
    typedef struct packed {
        logic [FETCH_ADDRESS_WIDTH-1:0] Address;
        logic [FETCH_DATA_WIDTH-1:0]    Instruction;
    } FetchEntry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous FIFO of fetch entries; flush beats push/pop.
// Latency: a pushed entry is visible at the head one cycle after its push edge (no fall-through).
// Backpressure: push into a full buffer is accepted only together with a pop; pop on empty is ignored.
//
// Ports:
//   clk, clk_rst       clock, synchronous active-high reset
//   push_vld/push_dat  write request and entry
//   pop_rdy            consumer takes the head this edge (ignored when empty)
//   flush              drop all entries and reset pointers
//   head_vld/head_dat  head entry (head_dat is zero while empty)
//   full, count        occupancy status
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter type entry_t = FetchEntry_t,
    parameter int  DEPTH   = FETCH_BUFFER_DEPTH
) (
    input  logic                   clk,
    input  logic                   clk_rst,
    input  logic                   push_vld,
    input  entry_t                 push_dat,
    input  logic                   pop_rdy,
    input  logic                   flush,
    output logic                   head_vld,
    output entry_t                 head_dat,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push;
    logic               do_pop;

    assign head_vld = (count_q != '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign count    = count_q;
    // Zero the head while empty so downstream never sees stale entries.
    assign head_dat = head_vld ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        do_pop   = pop_rdy & head_vld;
        // A full buffer frees its head slot on the same edge when popping.
        do_push  = push_vld & (~full | do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_dat;
                // DEPTH is a power of two, so the pointer wraps naturally.
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clk_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads the ROM combinationally and queues {address, instruction} for decode.
// Latency: first FetchValid one cycle after reset release; redirect target visible two edges after the redirect.
// Backpressure: FetchReady low with a full buffer stalls the PC; the head holds steady until accepted.
//
// Ports:
//   clk, clk_rst                       clock, synchronous active-high reset
//   InstructionAddress/InstructionIn   ROM address (= PC) and same-cycle ROM data
//   RedirectValid/RedirectAddress      reload PC and flush the buffer
//   Halt                               stop fetching; buffer keeps draining
//   FetchValid/FetchReady              head handshake toward decode
//   FetchInstruction/FetchAddress      head entry contents (zero while empty)
//   BufferCount                        occupied entries
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH = FETCH_ADDRESS_WIDTH,
    parameter int                       DATA_WIDTH    = FETCH_DATA_WIDTH,
    parameter int                       BUFFER_DEPTH  = FETCH_BUFFER_DEPTH,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = FETCH_RESET_VECTOR
) (
    input  logic                          clk,
    input  logic                          clk_rst,
    output logic [ADDRESS_WIDTH-1:0]      InstructionAddress,
    input  logic [DATA_WIDTH-1:0]         InstructionIn,
    input  logic                          RedirectValid,
    input  logic [ADDRESS_WIDTH-1:0]      RedirectAddress,
    input  logic                          Halt,
    output logic                          FetchValid,
    input  logic                          FetchReady,
    output logic [DATA_WIDTH-1:0]         FetchInstruction,
    output logic [ADDRESS_WIDTH-1:0]      FetchAddress,
    output logic [$clog2(BUFFER_DEPTH):0] BufferCount
);

    // Same layout as FetchEntry_t, but sized by this instance's parameters.
    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] Address;
        logic [DATA_WIDTH-1:0]    Instruction;
    } entry_t;

    logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
    logic                     pop;
    logic                     push;
    logic                     buf_full;
    logic                     head_vld;
    entry_t                   push_dat;
    entry_t                   head_dat;

    assign InstructionAddress = pc_q;
    assign FetchValid         = head_vld;
    assign FetchInstruction   = head_dat.Instruction;
    assign FetchAddress       = head_dat.Address;

    always_comb begin
        pop  = head_vld & FetchReady;
        // Redirect and halt both suppress the push; a full buffer only
        // accepts when its head is leaving on the same edge.
        push = ~clk_rst & ~RedirectValid & ~Halt & (~buf_full | pop);

        push_dat.Address     = pc_q;
        push_dat.Instruction = InstructionIn;

        pc_d = pc_q;
        if (RedirectValid) begin
            pc_d = RedirectAddress;
        end else if (push) begin
            // Wraps modulo 2^ADDRESS_WIDTH.
            pc_d = pc_q + ADDRESS_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clk_rst) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    // A pop coinciding with a redirect still completes; decode squashes it.
    fetch_buffer #(
        .entry_t (entry_t),
        .DEPTH   (BUFFER_DEPTH)
    ) u_fetch_buffer (
        .clk      (clk),
        .clk_rst  (clk_rst),
        .push_vld (push),
        .push_dat (push_dat),
        .pop_rdy  (pop),
        .flush    (RedirectValid),
        .head_vld (head_vld),
        .head_dat (head_dat),
        .full     (buf_full),
        .count    (BufferCount)
    );

endmodule
